nibble_serial_subtractor: RTL



---
 rtl/nibble_serial_subtractor_pkg.sv | 18 +
 rtl/nibble_serial_subtractor_cla_slice4.sv | 28 ++
 rtl/nibble_serial_subtractor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtract datapath.
package nibble_serial_subtractor_pkg;

  // Width of one arithmetic slice processed per clock.
  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Two's-complement overflow: carry into the MSB disagrees with carry out of it.
  function automatic logic ovf_calc(input logic c_msb_in, input logic c_out);
    return c_msb_in ^ c_out;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_cla_slice4.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla_slice4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  // Lookahead carries are flattened so no carry ripples through the slice.
  always_comb begin
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
         (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c3, c2, c1, ci};
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Computes a - b - bin one nibble per clock as a + ~b + ~bin through a single CLA slice.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / SLICE_W;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : gen_bad_width
    $error("WIDTH must be a non-zero multiple of 4");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [SLICE_W-1:0]       slice_s;
  logic                     slice_co;
  logic                     slice_c3;
  logic [WIDTH+SLICE_W-1:0] diff_shift;

  // One shared slice; the operand registers shift down so it always sees the current nibble.
  cla_slice4 u_slice (
    .x  (a_q[SLICE_W-1:0]),
    .y  (~b_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  assign in_ready = (state_q == StIdle) && !rst;

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    // New nibble enters at the top so the LSB nibble ends up at the bottom after NIBBLES steps.
    diff_shift  = {slice_s, diff_q};

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~bin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        diff_d  = diff_shift[WIDTH+SLICE_W-1:SLICE_W];
        carry_d = slice_co;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          bout_d      = ~slice_co;
          ovf_d       = ovf_calc(slice_c3, slice_co);
          zero_d      = (diff_d == '0);
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
